// File: rtl/sprite_storage.sv
// Sprite pixel store: SPRITE_NUM images of 4-bit pixels, packed two per byte.
// Byte-wide write port and 4-bit registered read port share one sprite select.
module sprite_storage #(
  parameter int SPRITE_NUM       = 16,
  parameter int SPRITE_ADDR_SIZE = 9
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(SPRITE_NUM)-1:0] sprite_select,
  input  logic                          w_en,
  input  logic [SPRITE_ADDR_SIZE:0]     w_addr,
  input  logic [7:0]                    w_data,
  input  logic                          r_en,
  input  logic [SPRITE_ADDR_SIZE:0]     r_addr,
  output logic [3:0]                    r_data
);

  localparam int SEL_W   = $clog2(SPRITE_NUM);
  localparam int BYTE_AW = SEL_W + SPRITE_ADDR_SIZE;
  localparam int DEPTH   = SPRITE_NUM << SPRITE_ADDR_SIZE;

  logic [7:0]         mem [DEPTH];
  logic [BYTE_AW-1:0] w_byte;
  logic [BYTE_AW-1:0] r_byte;
  logic               unused_w_lsb;

  // Pixel pair index selects the byte; the write LSB is meaningless.
  assign w_byte       = {sprite_select, w_addr[SPRITE_ADDR_SIZE:1]};
  assign r_byte       = {sprite_select, r_addr[SPRITE_ADDR_SIZE:1]};
  assign unused_w_lsb = w_addr[0];

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_en && !reset) begin
      mem[w_byte] <= w_data;
    end
  end

  // Non-blocking read alongside the write gives read-first collisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
    end else if (r_en) begin
      r_data <= r_addr[0] ? mem[r_byte][3:0] : mem[r_byte][7:4];
    end
  end

endmodule

// File: tb/tb_sprite_storage.sv
// Bench for sprite_storage: directed vector table plus randomized traffic
// checked against a pixel-level reference model.
module tb_sprite_storage;

  localparam int SPRITE_NUM       = 16;
  localparam int SPRITE_ADDR_SIZE = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sprite_select;
  logic       w_en;
  logic [9:0] w_addr;
  logic [7:0] w_data;
  logic       r_en;
  logic [9:0] r_addr;
  logic [3:0] r_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sprite_storage #(
    .SPRITE_NUM(SPRITE_NUM),
    .SPRITE_ADDR_SIZE(SPRITE_ADDR_SIZE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sprite_select(sprite_select),
    .w_en(w_en),
    .w_addr(w_addr),
    .w_data(w_data),
    .r_en(r_en),
    .r_addr(r_addr),
    .r_data(r_data)
  );

  typedef struct {
    logic       rst;
    logic [3:0] sel;
    logic       we;
    logic [9:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [9:0] ra;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] sel,
                              input logic we, input logic [9:0] wa, input logic [7:0] wd,
                              input logic re, input logic [9:0] ra, input logic [3:0] exp);
    vec_t v;
    v.rst = rst; v.sel = sel; v.we = we; v.wa = wa; v.wd = wd;
    v.re = re; v.ra = ra; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input logic rst, input logic [3:0] sel, input logic we,
                       input logic [9:0] wa, input logic [7:0] wd,
                       input logic re, input logic [9:0] ra);
    reset = rst; sprite_select = sel; w_en = we; w_addr = wa; w_data = wd;
    r_en = re; r_addr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] exp);
    checks++;
    if (r_data !== exp) begin
      failures++;
      $display("FAIL %s[%0d] r_data=%h expected=%h", name, idx, r_data, exp);
    end
  endtask

  // Reference model: pixels per sprite, restricted to the randomized window.
  logic [3:0] pix [4][16];
  bit         vld [4][16];

  initial begin
    logic [3:0] exp_r;
    bit         exp_known;

    reset = 1'b1; sprite_select = '0; w_en = 1'b0; w_addr = '0; w_data = '0;
    r_en = 1'b0; r_addr = '0;

    // Reset state
    drive(1, 0, 0, 0, 8'h00, 0, 0);
    drive(1, 0, 0, 0, 8'h00, 1, 0);
    check("reset", 0, 4'h0);

    // Packed writes then sequential reads on sprite 0
    vecs.push_back(mk(0, 0, 1, 0, 8'h12, 0, 0, 4'h0));
    vecs.push_back(mk(0, 0, 1, 2, 8'h34, 0, 0, 4'h0));
    vecs.push_back(mk(0, 0, 1, 4, 8'h56, 0, 0, 4'h0));
    vecs.push_back(mk(0, 0, 1, 6, 8'h78, 0, 0, 4'h0));
    for (int unsigned a = 0; a < 8; a++)
      vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 10'(a), 4'(a + 1)));
    // Sprite isolation
    vecs.push_back(mk(0, 1, 1, 2, 8'hAA, 0, 0, 4'h8));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1, 2, 4'hA));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 2, 4'h3));
    // Odd write address lands in the even pixel's byte
    vecs.push_back(mk(0, 0, 1, 5, 8'hBC, 0, 0, 4'h3));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 4, 4'hB));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 5, 4'hC));
    // Hold with r_en low
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 7, 4'hC));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 1, 4'hC));
    // Same-cycle collision is read-first
    vecs.push_back(mk(0, 0, 1, 0, 8'hFF, 1, 0, 4'h1));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 4'hF));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 1, 4'hF));
    // Reset drops the write and clears r_data until the next read
    vecs.push_back(mk(1, 0, 1, 0, 8'h99, 1, 0, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 4'h0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 4'hF));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 1, 4'hF));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].sel, vecs[i].we, vecs[i].wa, vecs[i].wd,
            vecs[i].re, vecs[i].ra);
      check("vec", i, vecs[i].exp);
    end

    // Write then read on the very next edge, across a sprite change
    drive(0, 3, 1, 10'd8, 8'h5A, 0, 0);
    drive(0, 2, 1, 10'd8, 8'hC3, 1, 10'd8);
    drive(0, 3, 0, 0, 8'h00, 1, 10'd9);
    check("seq_sel3_lo", 0, 4'hA);
    drive(0, 2, 0, 0, 8'h00, 1, 10'd8);
    check("seq_sel2_hi", 0, 4'hC);

    // Randomized traffic over sprites 0..3, pixels 0..15
    foreach (vld[s, p]) vld[s][p] = 1'b0;
    exp_r = 4'hC;
    exp_known = 1'b1;
    for (int i = 0; i < 600; i++) begin
      logic       rst, we, re;
      logic [1:0] sel;
      logic [3:0] wa, ra;
      logic [7:0] wd;
      int unsigned base;
      rst = ($urandom_range(0, 31) == 0);
      sel = 2'($urandom_range(0, 3));
      we  = 1'($urandom_range(0, 1));
      re  = 1'($urandom_range(0, 1));
      wa  = 4'($urandom_range(0, 15));
      ra  = 4'($urandom_range(0, 15));
      wd  = 8'($urandom);

      if (rst) begin
        exp_r = 4'h0; exp_known = 1'b1;
      end else if (re) begin
        exp_known = vld[sel][ra];
        exp_r     = pix[sel][ra];
      end
      if (!rst && we) begin
        base = {28'd0, wa} & ~32'd1;
        pix[sel][base]     = wd[7:4];
        pix[sel][base + 1] = wd[3:0];
        vld[sel][base]     = 1'b1;
        vld[sel][base + 1] = 1'b1;
      end

      drive(rst, {2'b00, sel}, we, {6'd0, wa}, wd, re, {6'd0, ra});
      if (exp_known) check("rand", i, exp_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_storage.md
# sprite_storage

On-chip pixel store for the sprite renderer, holding `SPRITE_NUM` independent sprite images at 4 bits per pixel (palette index). The SPI-side loader writes packed bytes (two pixels each) into the sprite chosen by `sprite_select`. The pixel pipeline reads single 4-bit pixels back from the same sprite with one cycle of registered latency. The memory is intended to map onto block RAM.

## Interface
Parameters (global, from `params.vh`):
- `SPRITE_NUM`, default 16: number of sprite slots; the select width is `$clog2(SPRITE_NUM)`.
- `SPRITE_ADDR_SIZE`, default 9: pixel address MSB index. Addresses are `SPRITE_ADDR_SIZE+1` bits, giving 2^(`SPRITE_ADDR_SIZE`+1) = 1024 pixels per sprite.

Ports:
- `clk` in 1: system clock; all activity on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `sprite_select` in `$clog2(SPRITE_NUM)`: sprite slot used by both the write port and the read port.
- `w_en` in 1: write strobe.
- `w_addr` in `SPRITE_ADDR_SIZE+1`: pixel address of the first pixel in the written byte.
- `w_data` in 8: two packed pixels.
- `r_en` in 1: read strobe.
- `r_addr` in `SPRITE_ADDR_SIZE+1`: pixel address to read.
- `r_data` out 4: registered pixel value.

## Operation
- Storage is `SPRITE_NUM` × 2^`SPRITE_ADDR_SIZE` bytes. Each byte holds two pixels.
- Pixel p of sprite s is located in byte (s, p>>1):
  - even p uses bits [7:4];
  - odd p uses bits [3:0].
- Write, when `w_en`=1 and `reset`=0:
  - byte (`sprite_select`, `w_addr`>>1) ← `w_data`;
  - `w_data[7:4]` is pixel `w_addr` and `w_data[3:0]` is pixel `w_addr`+1.
  - `w_addr[0]` is ignored, so an odd address writes the same byte as `w_addr`−1.
- Read, when `r_en`=1 and `reset`=0: `r_data` ← nibble `r_addr[0]` of byte (`sprite_select`, `r_addr`>>1).
- When `r_en`=0, `r_data` holds its previous value.
- `w_en` and `r_en` are independent. Both ports may be active in the same cycle, always on the same sprite.
- Reading and writing the same byte in the same cycle is read-first: `r_data` returns the old contents, and the new value is visible on the next read.
- Changing `sprite_select` takes effect on the next edge; there is no pipeline state to flush.
- Reset:
  - `r_data` ← 0;
  - writes and reads are suppressed while `reset`=1;
  - memory contents are not cleared (contents are undefined after power-up until written).
- Addresses never exceed the array, so no out-of-range behaviour exists.

## Timing
- Write latency: data is stored at the rising edge where `w_en`=1. A read issued on the following edge returns the new data.
- Read latency: 1 cycle. `r_addr`/`sprite_select` sampled at edge N appear on `r_data` after edge N; they are valid for the cycle between edge N and edge N+1.
- Throughput: one read and one byte-write per cycle, sustained.
- Reset mid-operation:
  - a write presented in a cycle with `reset`=1 is dropped;
  - `r_data` becomes 0 at that edge and stays 0 until the first read after `reset` deasserts.
- There is no handshake and no busy/ready signal; the block is always able to accept accesses.

## Test plan
- Packed write/read, sprite 0:
  - stimulus: write 0x12, 0x34, 0x56, 0x78 at `w_addr` 0, 2, 4, 6; then read `r_addr` 0..7 on consecutive cycles;
  - required response: `r_data` = 1, 2, 3, 4, 5, 6, 7, 8, each one cycle after its address.
- Sprite isolation:
  - stimulus: set `sprite_select`=1, write 0xAA at `w_addr` 2, then read `r_addr` 2; then set `sprite_select`=0 and read `r_addr` 2;
  - required response: 0xA from sprite 1, then 3 from sprite 0, which is unchanged.
- Odd write address:
  - stimulus: write 0xBC at `w_addr` 5 in sprite 0, then read addresses 4 and 5;
  - required response: 0xB then 0xC.
- Read hold and same-cycle collision:
  - stimulus: with `r_en`=0, change `r_addr`;
  - required response: `r_data` does not change.
  - stimulus: write 0xFF at address 0 in the same cycle as a read of address 0;
  - required response: the old value 1; a re-read of address 0 returns 0xF.
- Reset:
  - stimulus: assert `reset` for one cycle while `w_en`=1 with 0x99 at address 0;
  - required response: `r_data`=0 after the reset edge, and a later read of address 0 still returns the previously stored value (the write was dropped).
